// File: rtl/metronome_pipe.sv
// metronome_pipe
//   Generates per-stage advance strobes for an N-stage core. In sequential
//   mode one stage ticks per cycle, rotating 0..NUM_STAGES-1. In pipelined
//   mode every stage ticks every cycle. Handles multi-source stall, flush,
//   stall timeout, and keeps retire and stall counters.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   en          run enable
//   mode        0 = sequential, 1 = pipelined (sampled only in IDLE)
//   stall_req   per-source stall requests, OR-ed together
//   flush       restart the sequence from stage 0
//   tick        stage advance strobes (combinational)
//   phase       current sequential stage index
//   running     high in RUN or STALL
//   stalled     high in STALL
//   timeout     sticky stall-timeout flag, cleared only by reset
//   retire_cnt  completed instructions (wraps)
//   stall_cnt   total stall cycles (wraps)

module metronome_pipe #(
   parameter int NUM_STAGES = 5,
   parameter int STALL_SRCS = 2,
   parameter int CNT_W      = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          mode,
   input  logic [STALL_SRCS-1:0]         stall_req,
   input  logic                          flush,
   output logic [NUM_STAGES-1:0]         tick,
   output logic [$clog2(NUM_STAGES)-1:0] phase,
   output logic                          running,
   output logic                          stalled,
   output logic                          timeout,
   output logic [CNT_W-1:0]              retire_cnt,
   output logic [CNT_W-1:0]              stall_cnt
);

   localparam int                    PH_W       = $clog2(NUM_STAGES);
   localparam logic [PH_W-1:0]       LAST       = PH_W'(NUM_STAGES - 1);
   localparam int                    WAIT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(TIMEOUT);
   localparam logic [NUM_STAGES-1:0] ONE_HOT0   = NUM_STAGES'(1);

   typedef enum logic [1:0] {IDLE, RUN, STALL, FLUSH} state_t;

   state_t            state;
   logic              mode_q;
   logic [PH_W-1:0]   fill;
   logic [WAIT_W-1:0] wait_cnt;

   logic              stall_any;
   logic              active;
   logic              timeout_hit;
   logic              retire_now;
   logic [WAIT_W-1:0] wait_nxt;

   assign stall_any = |stall_req;
   assign active    = (state == RUN) || (state == STALL);
   assign running   = active;
   assign stalled   = (state == STALL);

   // wait_nxt is the length of the stall run including the current cycle;
   // only consulted while a stall is being requested.
   assign wait_nxt    = wait_cnt + 1'b1;
   assign timeout_hit = (TIMEOUT != 0) && (wait_nxt == WAIT_LIMIT);

   // An instruction retires on the last-stage tick (sequential) or on any
   // tick once the pipeline has filled (pipelined).
   assign retire_now = mode_q ? (fill == LAST) : (phase == LAST);

   // A STALL cycle whose requests have dropped ticks immediately, so the
   // sequence resumes without a bubble.
   always_comb begin
      tick = '0;
      if (active && !stall_any) begin
         tick = mode_q ? '1 : (ONE_HOT0 << phase);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         mode_q     <= 1'b0;
         phase      <= '0;
         fill       <= '0;
         wait_cnt   <= '0;
         timeout    <= 1'b0;
         retire_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  mode_q   <= mode;
                  phase    <= '0;
                  fill     <= '0;
                  wait_cnt <= '0;
                  state    <= RUN;
               end
            end

            RUN, STALL: begin
               if (flush) begin
                  // Flush outranks a concurrent stall, so that cycle is not
                  // counted as a stall cycle.
                  wait_cnt <= '0;
                  state    <= FLUSH;
               end else if (stall_any) begin
                  stall_cnt <= stall_cnt + 1'b1;
                  if (timeout_hit) begin
                     timeout  <= 1'b1;
                     wait_cnt <= '0;
                     state    <= FLUSH;
                  end else begin
                     wait_cnt <= wait_nxt;
                     state    <= STALL;
                  end
               end else begin
                  // Ticking cycle: advance the sequence.
                  wait_cnt <= '0;
                  if (retire_now) begin
                     retire_cnt <= retire_cnt + 1'b1;
                  end
                  if (mode_q) begin
                     phase <= '0;
                     if (fill != LAST) begin
                        fill <= fill + 1'b1;
                     end
                     state <= en ? RUN : IDLE;
                  end else begin
                     if (phase == LAST) begin
                        phase <= '0;
                        // Disable only takes effect at an instruction boundary.
                        state <= en ? RUN : IDLE;
                     end else begin
                        phase <= phase + 1'b1;
                        state <= RUN;
                     end
                  end
               end
            end

            FLUSH: begin
               phase    <= '0;
               fill     <= '0;
               wait_cnt <= '0;
               state    <= en ? RUN : IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
